// File: rtl/bus_initiator.sv
// Register-bus initiator: queues read/write commands in a small FIFO and drives one bus
// transfer per command. Define BUS_INITIATOR_STATS_EN to add write/read transfer counters.
module bus_initiator #(
   parameter int unsigned BUS_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CMD_DEPTH  = 4,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_cmd_valid,
   output logic                  o_cmd_ready,
   input  logic                  i_cmd_write,
   input  logic [BUS_WIDTH-1:0]  i_cmd_addr,
   input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic [BUS_WIDTH-1:0]  o_addr,
   output logic [DATA_WIDTH-1:0] o_wdata,
   output logic                  o_write,
   output logic                  o_sel,
   input  logic [DATA_WIDTH-1:0] i_rdata,
`ifdef BUS_INITIATOR_STATS_EN
   output logic [15:0]           o_wr_count,
   output logic [15:0]           o_rd_count,
`endif
   output logic                  o_busy
);

   localparam int unsigned AW = $clog2(CMD_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = 1 + BUS_WIDTH + DATA_WIDTH;
   localparam int unsigned CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   logic [EW-1:0]         r_mem [CMD_DEPTH];
   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [PW-1:0]         w_wr_ptr_d, w_rd_ptr_d;
   logic                  r_full, w_full_d;
   logic                  w_empty, w_push, w_pop;
   logic [EW-1:0]         w_head;

   state_e                r_state, w_state_d;
   logic [BUS_WIDTH-1:0]  r_addr, w_addr_d;
   logic [DATA_WIDTH-1:0] r_wdata, w_wdata_d;
   logic                  r_write, w_write_d;
   logic [CW-1:0]         r_cnt, w_cnt_d;
   logic                  r_rsp_valid, w_rsp_valid_d;
   logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_d;

   // Command FIFO; pointers carry one extra wrap bit to tell full from empty.
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign o_cmd_ready = i_rst_n & ~r_full;
   assign w_push      = i_cmd_valid & o_cmd_ready;
   assign w_pop       = (r_state == StIdle) & ~w_empty;
   assign w_wr_ptr_d  = w_push ? r_wr_ptr + PW'(1) : r_wr_ptr;
   assign w_rd_ptr_d  = w_pop  ? r_rd_ptr + PW'(1) : r_rd_ptr;
   assign w_full_d    = (w_wr_ptr_d[AW] != w_rd_ptr_d[AW]) &&
                        (w_wr_ptr_d[AW-1:0] == w_rd_ptr_d[AW-1:0]);
   assign w_head      = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {i_cmd_write, i_cmd_addr, i_cmd_wdata};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_d;
         r_rd_ptr <= w_rd_ptr_d;
         r_full   <= w_full_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_write     <= 1'b0;
         r_cnt       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_d;
         r_addr      <= w_addr_d;
         r_wdata     <= w_wdata_d;
         r_write     <= w_write_d;
         r_cnt       <= w_cnt_d;
         r_rsp_valid <= w_rsp_valid_d;
         r_rsp_rdata <= w_rsp_rdata_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_addr_d      = r_addr;
      w_wdata_d     = r_wdata;
      w_write_d     = r_write;
      w_cnt_d       = r_cnt;
      w_rsp_valid_d = r_rsp_valid;
      w_rsp_rdata_d = r_rsp_rdata;
      case (r_state)
         StIdle: begin
            if (!w_empty) begin
               {w_write_d, w_addr_d, w_wdata_d} = w_head;
               w_state_d = StIssue;
            end
         end
         StIssue: begin
            if (r_write) begin
               w_state_d = StIdle;
            end else begin
               w_cnt_d   = CW'(RD_LATENCY - 1);
               w_state_d = StWait;
            end
         end
         StWait: begin
            if (r_cnt == '0) begin
               w_rsp_rdata_d = i_rdata;
               w_rsp_valid_d = 1'b1;
               w_state_d     = StResp;
            end else begin
               w_cnt_d = r_cnt - CW'(1);
            end
         end
         StResp: begin
            if (i_rsp_ready) begin
               w_rsp_valid_d = 1'b0;
               w_state_d     = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign o_sel       = (r_state == StIssue);
   assign o_addr      = r_addr;
   assign o_wdata     = r_wdata;
   assign o_write     = r_write;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_rdata = r_rsp_rdata;
   assign o_busy      = ~w_empty | (r_state != StIdle);

`ifdef BUS_INITIATOR_STATS_EN
   logic [15:0] r_wr_count, r_rd_count;

   // Counters wrap naturally at 16 bits.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_count <= '0;
         r_rd_count <= '0;
      end else if (o_sel) begin
         if (r_write) begin
            r_wr_count <= r_wr_count + 16'd1;
         end else begin
            r_rd_count <= r_rd_count + 16'd1;
         end
      end
   end

   assign o_wr_count = r_wr_count;
   assign o_rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed table, stall/full sequences, random traffic
// against a transaction-level model, and a second instance with a 3-cycle read latency.
module tb_bus_initiator;

   localparam int BW    = 32;
   localparam int DW    = 64;
   localparam int DEPTH = 4;
   localparam int LAT   = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready;
   logic          write, sel, busy;
   logic [BW-1:0] cmd_addr, addr;
   logic [DW-1:0] cmd_wdata, rsp_rdata, wdata, rdata;

   logic          rst_n3, cmd_valid3, cmd_ready3, cmd_write3, rsp_valid3, rsp_ready3;
   logic          write3, sel3, busy3;
   logic [BW-1:0] cmd_addr3, addr3;
   logic [DW-1:0] cmd_wdata3, rsp_rdata3, wdata3, rdata3;
`ifdef BUS_INITIATOR_STATS_EN
   logic [15:0]   wr_count, rd_count, wr_count3, rd_count3;
`endif

   bus_initiator #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_write(cmd_write), .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
      .o_addr(addr), .o_wdata(wdata), .o_write(write), .o_sel(sel), .i_rdata(rdata),
`ifdef BUS_INITIATOR_STATS_EN
      .o_wr_count(wr_count), .o_rd_count(rd_count),
`endif
      .o_busy(busy)
   );

   bus_initiator #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .CMD_DEPTH(DEPTH), .RD_LATENCY(3)) dut3 (
      .i_clk(clk), .i_rst_n(rst_n3), .i_cmd_valid(cmd_valid3), .o_cmd_ready(cmd_ready3),
      .i_cmd_write(cmd_write3), .i_cmd_addr(cmd_addr3), .i_cmd_wdata(cmd_wdata3),
      .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3), .o_rsp_rdata(rsp_rdata3),
      .o_addr(addr3), .o_wdata(wdata3), .o_write(write3), .o_sel(sel3), .i_rdata(rdata3),
`ifdef BUS_INITIATOR_STATS_EN
      .o_wr_count(wr_count3), .o_rd_count(rd_count3),
`endif
      .o_busy(busy3)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: commands expected on the bus in order, read data owed back.
   typedef struct packed {
      logic          w;
      logic [BW-1:0] a;
      logic [DW-1:0] d;
   } cmd_t;

   cmd_t          exp_q[$];
   logic [DW-1:0] rsp_q[$];
   int            due = 0;
   bit            rd_out = 0;
   bit            prev_stall = 0;
   bit            expect_valid = 0;
   logic [DW-1:0] prev_rdata;
   bit            fix_en = 0;
   logic [DW-1:0] cur_rdata = '0;
   int            n_wr = 0;
   int            n_rd = 0;

   always @(negedge clk) begin : mon
      int   fifo_cnt;
      cmd_t e;
      rdata = {$urandom, $urandom};
      if (!rst_n) begin
         exp_q.delete();
         rsp_q.delete();
         due = 0;
         rd_out = 0;
         prev_stall = 0;
         expect_valid = 0;
      end else begin
         // A command leaves the FIFO the cycle before its sel.
         fifo_cnt = exp_q.size() - (sel ? 1 : 0);
         chk("cmd_ready_vs_occupancy", cmd_ready, fifo_cnt < DEPTH);
         chk("busy_vs_model", busy, (exp_q.size() > 0) || rd_out);
         if (expect_valid) chk("rsp_valid_latency", rsp_valid, 1'b1);
         expect_valid = 0;
         if (prev_stall) begin
            chk("rsp_hold_valid", rsp_valid, 1'b1);
            chk("rsp_hold_rdata", rsp_rdata, prev_rdata);
         end
         if (due > 0) begin
            due--;
            if (due == 0) begin
               rdata = fix_en ? cur_rdata : {$urandom, $urandom};
               rsp_q.push_back(rdata);
               expect_valid = 1;
               chk("rsp_valid_early", rsp_valid, 1'b0);
            end
         end
         if (sel) begin
            if (rd_out) chk("sel_while_read_pending", sel, 1'b0);
            if (exp_q.size() == 0) begin
               chk("sel_unexpected", sel, 1'b0);
            end else begin
               e = exp_q.pop_front();
               chk("bus_write", write, e.w);
               chk("bus_addr", addr, e.a);
               if (e.w) begin
                  chk("bus_wdata", wdata, e.d);
                  n_wr++;
               end else begin
                  due = LAT;
                  rd_out = 1;
                  n_rd++;
               end
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) chk("rsp_spurious", rsp_valid, 1'b0);
            else chk("rsp_rdata", rsp_rdata, rsp_q.pop_front());
            rd_out = 0;
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_rdata = rsp_rdata;
         if (cmd_valid && cmd_ready) exp_q.push_back({cmd_write, cmd_addr, cmd_wdata});
      end
   end

   task automatic send(input bit w, input logic [BW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      @(negedge clk);
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) timeout_fail("send_cmd_ready");
      step();
      cmd_valid = 1'b0;
   endtask

   typedef struct {
      bit            w;
      logic [BW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] rd;
      logic [DW-1:0] exp_rsp;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{1'b1, 32'h0000_0010, 64'h0000_0000_0000_A5A5, 64'h0, 64'h0};
      tbl[1] = '{1'b0, 32'h0000_0020, 64'h0, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234};
      tbl[2] = '{1'b1, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0};
      tbl[3] = '{1'b0, 32'h0000_0000, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D};
      tbl[4] = '{1'b1, 32'h8000_0000, 64'h0, 64'h0, 64'h0};
      tbl[5] = '{1'b0, 32'hFFFF_FFFF, 64'h0, 64'h5555_AAAA_5555_AAAA, 64'h5555_AAAA_5555_AAAA};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b1;
      rst_n3 = 1'b0; cmd_valid3 = 1'b0; cmd_write3 = 1'b0; cmd_addr3 = '0; cmd_wdata3 = '0;
      rsp_ready3 = 1'b1; rdata3 = '0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_sel", sel, 1'b0);
      chk("rst_write", write, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_addr", addr, '0);
      chk("rst_wdata", wdata, '0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      step();
      rst_n = 1'b1;
      step();

      // Directed single commands from idle: sel two cycles after accept.
      fix_en = 1;
      for (int i = 0; i < 6; i++) begin
         cur_rdata = tbl[i].rd;
         send(tbl[i].w, tbl[i].a, tbl[i].d);
         @(negedge clk);
         chk("tbl_no_sel_early", sel, 1'b0);
         @(negedge clk);
         chk("tbl_sel", sel, 1'b1);
         chk("tbl_write", write, tbl[i].w);
         chk("tbl_addr", addr, tbl[i].a);
         if (tbl[i].w) chk("tbl_wdata", wdata, tbl[i].d);
         @(negedge clk);
         chk("tbl_sel_one_cycle", sel, 1'b0);
         chk("tbl_rsp_valid_pre", rsp_valid, 1'b0);
         if (tbl[i].w) begin
            chk("tbl_busy_after_write", busy, 1'b0);
         end else begin
            @(negedge clk);
            chk("tbl_rsp_valid", rsp_valid, 1'b1);
            chk("tbl_rsp_rdata", rsp_rdata, tbl[i].exp_rsp);
         end
         step();
         step();
      end

      // Stalled read response while the FIFO fills up behind it.
      cur_rdata = 64'h1111_2222_3333_4444;
      rsp_ready = 1'b0;
      send(1'b0, 32'h40, '0);
      begin
         int n = 0;
         @(negedge clk);
         while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (!rsp_valid) timeout_fail("stall_rsp_valid");
      end
      step();
      for (int i = 0; i < 4; i++) send(1'b1, 32'h100 + 32'(i * 4), 64'(i + 1));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_cmd_ready_low", cmd_ready, 1'b0);
         chk("stall_no_sel", sel, 1'b0);
         chk("stall_rsp_valid", rsp_valid, 1'b1);
         chk("stall_rsp_rdata", rsp_rdata, 64'h1111_2222_3333_4444);
      end
      step();
      rsp_ready = 1'b1;
      begin
         int n = 0;
         @(negedge clk);
         while (busy && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("stall_drained", busy, 1'b0);
      end

      // Random traffic against the model.
      fix_en = 0;
      step();
      for (int i = 0; i < 600; i++) begin
         cmd_valid = ($urandom_range(0, 1) == 1);
         cmd_write = ($urandom_range(0, 1) == 1);
         cmd_addr  = $urandom;
         cmd_wdata = {$urandom, $urandom};
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      begin
         int n = 0;
         @(negedge clk);
         while (busy && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("random_drained", busy, 1'b0);
      end
`ifdef BUS_INITIATOR_STATS_EN
      chk("stats_wr_count", wr_count, 16'(n_wr));
      chk("stats_rd_count", rd_count, 16'(n_rd));
`endif

      // Latency-3 instance: read timing, then reset while waiting for data.
      step();
      rst_n3 = 1'b1;
      step();
      cmd_valid3 = 1'b1; cmd_write3 = 1'b0; cmd_addr3 = 32'h20;
      @(negedge clk);
      chk("l3_cmd_ready", cmd_ready3, 1'b1);
      step();
      cmd_valid3 = 1'b0;
      @(negedge clk);
      chk("l3_no_sel_early", sel3, 1'b0);
      @(negedge clk);
      chk("l3_sel", sel3, 1'b1);
      chk("l3_addr", addr3, 32'h20);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk("l3_rsp_valid_pre", rsp_valid3, 1'b0);
         rdata3 = (k == 3) ? 64'h1234 : {$urandom, $urandom};
      end
      @(negedge clk);
      rdata3 = {$urandom, $urandom};
      chk("l3_rsp_valid", rsp_valid3, 1'b1);
      chk("l3_rsp_rdata", rsp_rdata3, 64'h1234);
      @(negedge clk);
      chk("l3_rsp_done", rsp_valid3, 1'b0);
      chk("l3_idle", busy3, 1'b0);

      step();
      cmd_valid3 = 1'b1; cmd_addr3 = 32'h30;
      step();
      cmd_valid3 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("l3r_sel", sel3, 1'b1);
      @(negedge clk);
      rst_n3 = 1'b0;
      @(negedge clk);
      chk("l3r_sel", sel3, 1'b0);
      chk("l3r_rsp_valid", rsp_valid3, 1'b0);
      chk("l3r_busy", busy3, 1'b0);
      chk("l3r_cmd_ready", cmd_ready3, 1'b0);
      chk("l3r_addr", addr3, '0);
      rst_n3 = 1'b1;
      rdata3 = 64'h9999;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("l3r_no_rsp", rsp_valid3, 1'b0);
         chk("l3r_no_sel", sel3, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
